// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add multiplier that drives an external combinational
// ALU. It alternates a zero test of the remaining multiplier (OR with 0) with an
// accumulate step (ADD). It stops as soon as no multiplier bits remain.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; ALU parked on OR 0|0
// TEST  | ALU ORs remaining multiplier with 0; zero flag ends the loop
// ACC   | ALU adds (mplier[0] ? mcand : 0) into acc; operands shift
// DONE  | one-cycle done pulse; product already holds the result
module alu_mul_sequencer #(
  parameter int          WIDTH  = 64,
  parameter logic [3:0]  ADD_OP = 4'b0010,
  parameter logic [3:0]  OR_OP  = 4'b0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  // Encoding chosen so that busy is a single state bit (TEST and ACC share bit 0).
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_TEST = 2'b01,
    S_ACC  = 2'b11,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] product_q, product_d;

  // State and datapath registers; reset clears everything so no partial result survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
    end
  end

  // Next-state and datapath update: start is honoured only in IDLE.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = multiplicand;
          mplier_d = multiplier;
          acc_d    = '0;
          state_d  = S_TEST;
        end
      end
      S_TEST: begin
        if (alu_zero) begin
          product_d = acc_q;
          state_d   = S_DONE;
        end else begin
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_d    = alu_result;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        state_d  = S_TEST;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ALU operand/opcode steering, decoded from registered state only.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OR_OP;
    unique case (state_q)
      S_TEST: begin
        alu_a  = mplier_q;
        alu_b  = '0;
        alu_op = OR_OP;
      end
      S_ACC: begin
        alu_a  = acc_q;
        alu_b  = mplier_q[0] ? mcand_q : '0;
        alu_op = ADD_OP;
      end
      default: begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OR_OP;
      end
    endcase
  end

  assign busy    = state_q[0];
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural 64-bit ALU as the datapath.
module tb_alu_mul_sequencer;

  localparam logic [3:0] ADD_OP = 4'b0010;
  localparam logic [3:0] OR_OP  = 4'b0001;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_op;
  logic [63:0] alu_result;
  logic        alu_zero;

  int pass_cnt = 0;
  int total    = 0;
  int cyc;

  alu_mul_sequencer #(.WIDTH(64), .ADD_OP(ADD_OP), .OR_OP(OR_OP)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero)
  );

  // Team ALU stand-in: add, or; anything else yields zero.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ADD_OP:  alu_result = alu_a + alu_b;
      OR_OP:   alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == 64'd0);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one multiply and follow it to DONE; cycle 1 is the period right after the accepting edge.
  task automatic run_mul(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_p, input int exp_cyc);
    int          c;
    logic        alt_ok;
    logic        stable_ok;
    logic [63:0] p0;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    p0           = product;
    tick();
    start        = 1'b0;
    multiplicand = 64'hDEAD_BEEF_0BAD_F00D;
    multiplier   = 64'hFFFF_0000_FFFF_0000;
    c         = 1;
    alt_ok    = 1'b1;
    stable_ok = 1'b1;
    while (!done && c < 300) begin
      if (!busy) alt_ok = 1'b0;
      if (alu_op !== ((c % 2 == 1) ? OR_OP : ADD_OP)) alt_ok = 1'b0;
      if (product !== p0) stable_ok = 1'b0;
      tick();
      c++;
    end
    check({tag, "_latency"}, 64'(c), 64'(exp_cyc));
    check({tag, "_product"}, product, exp_p);
    check({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
    check({tag, "_op_alternates"}, {63'd0, alt_ok}, 64'd1);
    check({tag, "_product_stable"}, {63'd0, stable_ok}, 64'd1);
    tick();
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    check({tag, "_product_held"}, product, exp_p);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    tick();
    tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_alu_op", {60'd0, alu_op}, {60'd0, OR_OP});
    check("rst_alu_a", alu_a, 64'd0);
    reset = 1'b0;
    tick();
    check("idle_busy", {63'd0, busy}, 64'd0);

    run_mul("zero", 64'h1234, 64'd0, 64'd0, 2);
    run_mul("basic", 64'd3, 64'd5, 64'd15, 8);
    run_mul("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 6);
    run_mul("worst", 64'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 130);

    // start held high throughout: later operands and the DONE-cycle start are ignored
    multiplicand = 64'd3;
    multiplier   = 64'd5;
    start        = 1'b1;
    tick();
    multiplicand = 64'd7;
    multiplier   = 64'd7;
    cyc = 1;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
    check("hs_first_latency", 64'(cyc), 64'd8);
    check("hs_first_product", product, 64'd15);
    tick();
    check("hs_done_start_ignored", {63'd0, busy}, 64'd0);
    tick();
    check("hs_idle_start_accepted", {63'd0, busy}, 64'd1);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
    check("hs_second_latency", 64'(cyc), 64'd8);
    check("hs_second_product", product, 64'd49);
    tick();

    // reset in cycle 5 of 7 x 9
    multiplicand = 64'd7;
    multiplier   = 64'd9;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("midrst_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #2;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_product", product, 64'd0);
    check("midrst_alu_op", {60'd0, alu_op}, {60'd0, OR_OP});
    reset = 1'b0;
    tick();
    check("midrst_idle", {63'd0, busy}, 64'd0);
    run_mul("fresh", 64'd7, 64'd9, 64'd63, 10);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
